// File: rtl/instr_prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch front-end.
package instr_prefetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instr} entries; flush wins over push/pop.
module prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  fetch_entry_t               wdata_i,
  output fetch_entry_t               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_eff, pop_eff;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);

  // Pointer and occupancy next-state; pointers wrap at DEPTH, which need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array needs no reset; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (push_eff && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // The credit scheme upstream must never push into a full buffer without a pop.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i) assert (!(push_i && full_o && !pop_i));
  end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction fetch front-end: sequential fetch with grant stalls, credit-limited
// prefetch buffer, and redirect handling that drops in-flight responses.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        fetch_en,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [1:0]    outstanding_q, outstanding_d;
  logic [1:0]    discard_q, discard_d;
  logic [31:0]   target_al;
  logic          credit_ok, grant;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_wdata, fifo_rdata;

  assign target_al = branch_target & ~32'h3;

  // Every issued request owns a buffer slot, so returning words can never overflow.
  assign credit_ok = !fifo_full && ((32'(fifo_count) + 32'(outstanding_q)) < 32'(DEPTH));
  // rst_n gating keeps req low while reset is held even if fetch_en is already high.
  assign ibus_req  = rst_n && fetch_en && !branch && credit_ok;
  assign ibus_addr = fetch_pc_q;
  assign grant     = ibus_req && ibus_gnt;

  assign fifo_wdata  = '{pc: resp_pc_q, instr: ibus_rdata};
  assign fifo_pop    = !fifo_empty && instr_ready && !branch;
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_rdata.instr;
  assign instr_pc    = fifo_rdata.pc;

  // Fetch/response bookkeeping; a redirect overrides everything else in its cycle.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fifo_push     = 1'b0;
    if (branch) begin
      fetch_pc_d    = target_al;
      resp_pc_d     = target_al;
      outstanding_d = outstanding_q - {1'b0, ibus_rvalid};
      discard_d     = outstanding_q - {1'b0, ibus_rvalid};
    end else begin
      if (grant) fetch_pc_d = pc_next(fetch_pc_q);
      outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, ibus_rvalid};
      if (ibus_rvalid) begin
        if (discard_q != 2'd0) begin
          discard_d = discard_q - 2'd1;
        end else begin
          fifo_push = 1'b1;
          resp_pc_d = pc_next(resp_pc_q);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (branch),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: code memory returns word == address one cycle after grant.
module tb_instr_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt = 1'b0;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic        fetch_en = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_target = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int          grants = 0;
  int          pops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch = RESET_PC;

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ibus_req      (ibus_req),
    .ibus_addr     (ibus_addr),
    .ibus_gnt      (ibus_gnt),
    .ibus_rvalid   (ibus_rvalid),
    .ibus_rdata    (ibus_rdata),
    .fetch_en      (fetch_en),
    .branch        (branch),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  // Code memory model: response one cycle after grant, data equals address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibus_rvalid <= 1'b0;
      ibus_rdata  <= '0;
    end else begin
      ibus_rvalid <= ibus_req && ibus_gnt;
      ibus_rdata  <= ibus_addr;
    end
  end

  // Mid-cycle observation: grants push expected PCs, accepted outputs pop and compare.
  task automatic sample();
    logic [31:0] e;
    @(negedge clk);
    if (branch) begin
      vectors++;
      if (ibus_req !== 1'b0) begin
        miscompares++;
        $display("FAIL req_in_branch: got %b expected 0", ibus_req);
      end
      exp_q.delete();
      exp_fetch = branch_target & ~32'h3;
    end else begin
      if (ibus_req === 1'b1 && ibus_gnt === 1'b1) begin
        vectors++;
        grants++;
        if (ibus_addr !== exp_fetch) begin
          miscompares++;
          $display("FAIL grant_addr: got %h expected %h", ibus_addr, exp_fetch);
        end
        exp_q.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        vectors++;
        pops++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output: got pc %h expected none", instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instr_pc !== e || instr !== e) begin
            miscompares++;
            $display("FAIL output_order: got pc %h instr %h expected %h", instr_pc, instr, e);
          end
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    branch = 1'b0;
    instr_ready = 1'b0;
    ibus_gnt = 1'b0;
    exp_q.delete();
    exp_fetch = RESET_PC;
    grants = 0;
    pops = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fetch_en = 1'b1;
    #2;
    vectors++;
    if (ibus_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", ibus_req); end
    vectors++;
    if (ibus_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_addr: got %h expected %h", ibus_addr, RESET_PC); end
    vectors++;
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
  endtask

  task automatic test_cold_start();
    reset_dut();
    fetch_en = 1'b1; instr_ready = 1'b1; ibus_gnt = 1'b1;
    sample();
    vectors++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin
      miscompares++; $display("FAIL cold_c0_req: got req %b addr %h expected 1 0", ibus_req, ibus_addr);
    end
    advance();
    sample();
    vectors++;
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL cold_c1_valid: got %b expected 0", instr_valid); end
    advance();
    for (int c = 2; c < 10; c++) begin
      sample();
      vectors++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (c - 2))) begin
        miscompares++;
        $display("FAIL cold_stream c%0d: got valid %b pc %h expected 1 %h", c, instr_valid, instr_pc, 32'(4 * (c - 2)));
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    fetch_en = 1'b1; ibus_gnt = 1'b1; instr_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (c >= 4) begin
        vectors++;
        if (ibus_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_off c%0d: got %b expected 0", c, ibus_req); end
      end
      advance();
    end
    vectors++;
    if (grants !== 4) begin miscompares++; $display("FAIL bp_grants: got %0d expected 4", grants); end
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      miscompares++; $display("FAIL bp_head: got valid %b pc %h expected 1 0", instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    sample();
    vectors++;
    if (ibus_req !== 1'b0) begin miscompares++; $display("FAIL bp_drain0_req: got %b expected 0", ibus_req); end
    advance();
    sample();
    vectors++;
    if (ibus_req !== 1'b1) begin miscompares++; $display("FAIL bp_resume_req: got %b expected 1", ibus_req); end
    advance();
    step(10);
  endtask

  task automatic test_grant_stall();
    reset_dut();
    fetch_en = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      ibus_gnt = !(c >= 4 && c <= 6);
      sample();
      if (c >= 4 && c <= 6) begin
        vectors++;
        if (ibus_req !== 1'b1 || ibus_addr !== 32'h10) begin
          miscompares++; $display("FAIL stall_addr c%0d: got req %b addr %h expected 1 10", c, ibus_req, ibus_addr);
        end
      end
      advance();
    end
    vectors++;
    if (pops !== 11) begin miscompares++; $display("FAIL stall_pops: got %0d expected 11", pops); end
  endtask

  task automatic test_branch_inflight();
    reset_dut();
    fetch_en = 1'b1; ibus_gnt = 1'b1; instr_ready = 1'b0;
    step(3);
    branch = 1'b1; branch_target = 32'h100;
    sample();
    advance();
    branch = 1'b0; instr_ready = 1'b1;
    sample();
    vectors++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h100) begin
      miscompares++; $display("FAIL br1_req: got req %b addr %h expected 1 100", ibus_req, ibus_addr);
    end
    advance();
    sample();
    vectors++;
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL br1_stale: got valid %b pc %h expected 0", instr_valid, instr_pc); end
    advance();
    sample();
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
      miscompares++; $display("FAIL br1_first: got valid %b pc %h expected 1 100", instr_valid, instr_pc);
    end
    advance();
    step(4);
  endtask

  task automatic test_branch_rvalid_pop();
    reset_dut();
    fetch_en = 1'b1; ibus_gnt = 1'b1; instr_ready = 1'b1;
    step(5);
    vectors++;
    if (ibus_rvalid !== 1'b1 || instr_valid !== 1'b1) begin
      miscompares++; $display("FAIL br2_setup: got rvalid %b valid %b expected 1 1", ibus_rvalid, instr_valid);
    end
    branch = 1'b1; branch_target = 32'h203;
    sample();
    advance();
    branch = 1'b0;
    sample();
    vectors++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h200) begin
      miscompares++; $display("FAIL br2_req: got req %b addr %h expected 1 200", ibus_req, ibus_addr);
    end
    advance();
    sample();
    vectors++;
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL br2_stale: got valid %b pc %h expected 0", instr_valid, instr_pc); end
    advance();
    sample();
    vectors++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
      miscompares++; $display("FAIL br2_first: got valid %b pc %h expected 1 200", instr_valid, instr_pc);
    end
    advance();
    step(3);
  endtask

  task automatic test_wrap();
    int base;
    reset_dut();
    fetch_en = 1'b1; ibus_gnt = 1'b1; instr_ready = 1'b1;
    step(2);
    branch = 1'b1; branch_target = 32'hFFFF_FFF8;
    sample();
    advance();
    branch = 1'b0;
    base = pops;
    step(8);
    vectors++;
    if (pops - base !== 6) begin miscompares++; $display("FAIL wrap_pops: got %0d expected 6", pops - base); end
  endtask

  task automatic test_fetch_en();
    reset_dut();
    ibus_gnt = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      fetch_en = (c < 4);
      sample();
      if (c >= 4) begin
        vectors++;
        if (ibus_req !== 1'b0) begin miscompares++; $display("FAIL fen_req c%0d: got %b expected 0", c, ibus_req); end
      end
      advance();
    end
    vectors++;
    if (pops !== 4 || instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL fen_drain: got pops %0d valid %b expected 4 0", pops, instr_valid);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    fetch_en = 1'b1; ibus_gnt = 1'b1; instr_ready = 1'b1;
    step(3);
    vectors++;
    if (dut.outstanding_q !== 2'd1 || instr_valid !== 1'b1) begin
      miscompares++; $display("FAIL ar_setup: got outstanding %0d valid %b expected 1 1", dut.outstanding_q, instr_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || ibus_req !== 1'b0 || dut.discard_q !== 2'd0) begin
      miscompares++;
      $display("FAIL ar_immediate: got valid %b req %b discard %0d expected 0 0 0", instr_valid, ibus_req, dut.discard_q);
    end
    exp_q.delete();
    exp_fetch = RESET_PC;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sample();
    vectors++;
    if (ibus_req !== 1'b1 || ibus_addr !== RESET_PC) begin
      miscompares++; $display("FAIL ar_restart: got req %b addr %h expected 1 %h", ibus_req, ibus_addr, RESET_PC);
    end
    advance();
    step(6);
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_backpressure();
    test_grant_stall();
    test_branch_inflight();
    test_branch_rvalid_pop();
    test_wrap();
    test_fetch_en();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
